// File: rtl/instr_prefetch_unit.sv
// Instruction prefetch unit: issues word fetches, buffers responses in a DEPTH-entry FIFO
// and hands {instruction, pc} to decode. Optional macro IFU_BYPASS_EN forwards a live response past an empty FIFO.
module instr_prefetch_unit #(
  parameter int unsigned              DATA_WIDTH = 32,
  parameter int unsigned              DEPTH      = 4,
  parameter logic [DATA_WIDTH-1:0]    RESET_PC   = '0
) (
  input  logic                        clk,
  input  logic                        arst_n,
  output logic                        imem_req,
  output logic [DATA_WIDTH-1:0]       imem_addr,
  input  logic                        imem_valid,
  input  logic [DATA_WIDTH-1:0]       imem_rdata,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  output logic [DATA_WIDTH-1:0]       instruction,
  output logic [DATA_WIDTH-1:0]       instr_pc,
  input  logic                        redirect_valid,
  input  logic [DATA_WIDTH-1:0]       redirect_pc,
  output logic [$clog2(DEPTH):0]      fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  // Handshake: an entry transfers to decode in a cycle where instr_valid and instr_ready
  // are both high; while instr_valid=1 and instr_ready=0 instruction/instr_pc hold stable.

  logic [DATA_WIDTH-1:0] r_mem_instr [DEPTH];
  logic [DATA_WIDTH-1:0] r_mem_pc    [DEPTH];
  logic [AW-1:0]         r_wr_ptr;
  logic [AW-1:0]         r_rd_ptr;
  logic [CW-1:0]         r_count;
  logic [DATA_WIDTH-1:0] r_fetch_pc;
  logic                  r_inflight;
  logic [DATA_WIDTH-1:0] r_inflight_pc;
  logic                  r_run;
  logic [DATA_WIDTH-1:0] r_last_instr;
  logic [DATA_WIDTH-1:0] r_last_pc;

  logic                  w_fifo_empty;
  logic                  w_live;
  logic                  w_bypass;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_issue;
  logic [CW-1:0]         w_occupancy;
  logic                  w_unused;

  assign w_unused     = ^redirect_pc[1:0];
  assign w_fifo_empty = (r_count == '0);
  // A response only counts when its request is outstanding and no redirect kills it.
  assign w_live       = imem_valid & r_inflight & ~redirect_valid;
  assign w_occupancy  = r_count + CW'(r_inflight);
  assign w_issue      = r_run & ~redirect_valid & (w_occupancy < CW'(DEPTH));

`ifdef IFU_BYPASS_EN
  assign w_bypass = w_fifo_empty & w_live;
  assign w_push   = w_live & ~(w_bypass & instr_ready);
`else
  assign w_bypass = 1'b0;
  assign w_push   = w_live;
`endif

  assign w_pop      = ~w_fifo_empty & instr_ready & ~redirect_valid;
  assign imem_req   = w_issue;
  assign imem_addr  = r_fetch_pc;
  assign fifo_count = r_count;

  always_comb begin
    instr_valid = ~w_fifo_empty | w_bypass;
    instruction = r_last_instr;
    instr_pc    = r_last_pc;
    if (!w_fifo_empty) begin
      instruction = r_mem_instr[r_rd_ptr];
      instr_pc    = r_mem_pc[r_rd_ptr];
    end else if (w_bypass) begin
      instruction = imem_rdata;
      instr_pc    = r_inflight_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_instr[r_wr_ptr] <= imem_rdata;
      r_mem_pc[r_wr_ptr]    <= r_inflight_pc;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_count       <= '0;
      r_fetch_pc    <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_run         <= 1'b0;
      r_last_instr  <= '0;
      r_last_pc     <= '0;
    end else begin
      r_run <= 1'b1;
      // Remember what was shown so an empty FIFO keeps presenting the last word.
      if (instr_valid) begin
        r_last_instr <= instruction;
        r_last_pc    <= instr_pc;
      end
      if (redirect_valid) begin
        r_fetch_pc <= {redirect_pc[DATA_WIDTH-1:2], 2'b00};
        r_inflight <= 1'b0;
        r_wr_ptr   <= '0;
        r_rd_ptr   <= '0;
        r_count    <= '0;
      end else begin
        r_inflight <= w_issue;
        if (w_issue) begin
          r_inflight_pc <= r_fetch_pc;
          r_fetch_pc    <= r_fetch_pc + DATA_WIDTH'(4);
        end
        if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
        if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
        r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
    end
  end

endmodule
